// File: rtl/fb_write_queue_pkg.sv
// Frame-buffer types shared by the CPU->video CDC stage, the write queue and the RAM.
package fb_pkg;

    localparam int FB_ADDR_W    = 12;
    localparam int FB_DATA_W    = 12;
    localparam int DROP_CNT_MAX = 255;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fb_wr_t;

endpackage

// File: rtl/fb_write_queue_if.sv
// Signal bundle between the CDC write pulses, the scanout arbiter and the frame-buffer write port.
interface fb_write_queue_if
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int DEPTH  = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    // in_we is a one-cycle fire-and-forget pulse with no ready: the queue always
    // takes it, and a write that finds no room is dropped and counted instead of stalling.
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              in_we;
    logic              ram_busy;
    logic              clear_stats;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_we;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;
    logic [7:0]        drop_count;

    modport master (
        output in_addr, in_data, in_we, ram_busy, clear_stats,
        input  ram_addr, ram_data, ram_we, fifo_level, overflow, drop_count
    );

    modport slave (
        input  in_addr, in_data, in_we, ram_busy, clear_stats,
        output ram_addr, ram_data, ram_we, fifo_level, overflow, drop_count
    );

endinterface

// File: rtl/fb_write_queue_mem.sv
// Simple dual-port storage for the write queue: synchronous write, asynchronous read at rd_ptr.
module fb_fifo_mem #(
    parameter int W     = 24,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fb_write_queue.sv
// Pixel-domain write queue: buffers synchronized CPU writes and drains them into the
// frame-buffer RAM only in cycles that scanout leaves the port free.
module fb_write_queue
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int DEPTH  = 16,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic           clk_pixel,
    input  logic           rst_pixel_n,
    fb_write_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int W     = ADDR_W + DATA_W;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [W-1:0]      head;
    logic              pop, push, drop;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_data_q;
    logic              ram_we_q;
    logic              overflow_q;
    logic [7:0]        drop_count_q;

    // Pop looks only at the registered level, so an entry written this edge can never bypass.
    assign pop  = (level != '0) && !bus.ram_busy;
    assign push = bus.in_we && ((level < LVL_W'(DEPTH)) || pop);
    assign drop = bus.in_we && !push;

    fb_fifo_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk_pixel),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({bus.in_addr, bus.in_data}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
        if (!rst_pixel_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
        if (!rst_pixel_n) begin
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            ram_we_q <= pop;
            if (pop) {ram_addr_q, ram_data_q} <= head;
        end
    end

    // A drop in the same cycle as clear_stats wins: the fresh drop is the first one counted.
    always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
        if (!rst_pixel_n) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (bus.clear_stats)
                drop_count_q <= 8'd1;
            else if (drop_count_q != 8'(DROP_CNT_MAX))
                drop_count_q <= drop_count_q + 8'd1;
        end else if (bus.clear_stats) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end
    end

    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_data   = ram_data_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.fifo_level = level;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_count_q;

endmodule

// File: tb/tb_fb_write_queue.sv
// Bench for fb_write_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fb_write_queue;
    import fb_pkg::*;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 16;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_write_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    fb_write_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) dut (
        .clk_pixel   (clk),
        .rst_pixel_n (rst_n),
        .bus         (bus.slave)
    );

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- reference model ----------------
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    fb_wr_t m_out;
    logic   m_we;
    logic   m_ovf;
    int     m_cnt;

    task automatic model_reset();
        exp_q.delete();
        m_out = '0;
        m_we  = 1'b0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    // Apply one clock's worth of the queue rules to the model using the current inputs.
    task automatic model_step();
        bit do_pop, do_push, do_drop;
        do_pop  = (exp_q.size() != 0) && !bus.ram_busy;
        do_push = bus.in_we && ((exp_q.size() < DEPTH) || do_pop);
        do_drop = bus.in_we && !do_push;
        m_we = do_pop;
        if (do_pop) m_out = exp_q.pop_front();
        if (do_push) exp_q.push_back({bus.in_addr, bus.in_data});
        if (do_drop) begin
            m_ovf = 1'b1;
            m_cnt = bus.clear_stats ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (bus.clear_stats) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_addr     = '0;
        bus.in_data     = '0;
        bus.in_we       = 1'b0;
        bus.ram_busy    = 1'b0;
        bus.clear_stats = 1'b0;
    endtask

    task automatic fill_blocked(input int n);
        bus.ram_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.in_addr = ADDR_W'(i);
            bus.in_data = ADDR_W'($urandom_range(0, 4095));
            bus.in_we   = 1'b1;
            cycle();
        end
        bus.in_we = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %0h need 0", bus.ram_we); end
        n_checks++;
        if (bus.ram_addr !== '0) begin n_err++; $display("FAIL reset_ram_addr: got %0h need 0", bus.ram_addr); end
        n_checks++;
        if (bus.ram_data !== '0) begin n_err++; $display("FAIL reset_ram_data: got %0h need 0", bus.ram_data); end
        n_checks++;
        if (bus.fifo_level !== '0) begin n_err++; $display("FAIL reset_level: got %0d need 0", bus.fifo_level); end
        n_checks++;
        if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0h need 0", bus.overflow); end
        n_checks++;
        if (bus.drop_count !== 8'd0) begin n_err++; $display("FAIL reset_drop_count: got %0d need 0", bus.drop_count); end
        n_checks++;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_single_write();
        bus.ram_busy = 1'b0;
        bus.in_addr  = 12'h123;
        bus.in_data  = 12'hABC;
        bus.in_we    = 1'b1;
        cycle();
        bus.in_we = 1'b0;
        if (bus.fifo_level !== LVL_W'(1)) begin n_err++; $display("FAIL single_level_after_accept: got %0d need 1", bus.fifo_level); end
        n_checks++;
        if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got %0h need 0", bus.ram_we); end
        n_checks++;
        cycle();
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 12'h123 || bus.ram_data !== 12'hABC) begin
            n_err++;
            $display("FAIL single_issue: got we=%0h %0h/%0h need we=1 123/abc", bus.ram_we, bus.ram_addr, bus.ram_data);
        end
        n_checks++;
        if (bus.fifo_level !== '0) begin n_err++; $display("FAIL single_level_drained: got %0d need 0", bus.fifo_level); end
        n_checks++;
        cycle();
        if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL single_one_strobe: got %0h need 0", bus.ram_we); end
        n_checks++;
    endtask

    task automatic test_fill_drain();
        bus.ram_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.in_addr = ADDR_W'(i);
            bus.in_data = DATA_W'($urandom_range(0, 4095));
            bus.in_we   = 1'b1;
            cycle();
            if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL fill_busy_we[%0d]: got %0h need 0", i, bus.ram_we); end
            n_checks++;
        end
        bus.in_we = 1'b0;
        if (bus.fifo_level !== LVL_W'(DEPTH)) begin n_err++; $display("FAIL fill_level: got %0d need %0d", bus.fifo_level, DEPTH); end
        n_checks++;
        bus.ram_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            if (bus.ram_we !== 1'b1 || bus.ram_addr !== ADDR_W'(i) || bus.ram_data !== m_out.data) begin
                n_err++;
                $display("FAIL drain_order[%0d]: got we=%0h %0h/%0h need we=1 %0h/%0h",
                         i, bus.ram_we, bus.ram_addr, bus.ram_data, i, m_out.data);
            end
            n_checks++;
        end
        cycle();
        if (bus.ram_we !== 1'b0 || bus.fifo_level !== '0) begin
            n_err++;
            $display("FAIL drain_done: got we=%0h level=%0d need 0/0", bus.ram_we, bus.fifo_level);
        end
        n_checks++;
    endtask

    task automatic test_overflow();
        fill_blocked(DEPTH);
        for (int i = 0; i < 3; i++) begin
            bus.in_addr = ADDR_W'($urandom_range(0, 4095));
            bus.in_we   = 1'b1;
            cycle();
        end
        bus.in_we = 1'b0;
        if (bus.overflow !== 1'b1 || bus.drop_count !== 8'd3 || bus.fifo_level !== LVL_W'(DEPTH)) begin
            n_err++;
            $display("FAIL overflow_three: got ovf=%0h cnt=%0d level=%0d need 1/3/16", bus.overflow, bus.drop_count, bus.fifo_level);
        end
        n_checks++;
        bus.clear_stats = 1'b1;
        bus.in_we       = 1'b1;
        cycle();
        bus.in_we = 1'b0;
        if (bus.overflow !== 1'b1 || bus.drop_count !== 8'd1) begin
            n_err++;
            $display("FAIL clear_with_drop: got ovf=%0h cnt=%0d need 1/1", bus.overflow, bus.drop_count);
        end
        n_checks++;
        cycle();
        bus.clear_stats = 1'b0;
        if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin
            n_err++;
            $display("FAIL clear_alone: got ovf=%0h cnt=%0d need 0/0", bus.overflow, bus.drop_count);
        end
        n_checks++;
    endtask

    task automatic test_full_push_pop();
        bus.ram_busy = 1'b0;
        bus.in_addr  = 12'hFEE;
        bus.in_data  = 12'h5A5;
        bus.in_we    = 1'b1;
        cycle();
        bus.in_we = 1'b0;
        if (bus.fifo_level !== LVL_W'(DEPTH) || bus.overflow !== 1'b0 || bus.drop_count !== 8'd0 || bus.ram_we !== 1'b1) begin
            n_err++;
            $display("FAIL full_push_pop: got level=%0d ovf=%0h cnt=%0d we=%0h need 16/0/0/1",
                     bus.fifo_level, bus.overflow, bus.drop_count, bus.ram_we);
        end
        n_checks++;
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle();
            if (bus.ram_we !== m_we || bus.ram_addr !== m_out.addr || bus.ram_data !== m_out.data) begin
                n_err++;
                $display("FAIL full_push_pop_drain[%0d]: got we=%0h %0h/%0h need we=%0h %0h/%0h",
                         i, bus.ram_we, bus.ram_addr, bus.ram_data, m_we, m_out.addr, m_out.data);
            end
            n_checks++;
        end
        if (m_out.addr !== 12'hFEE || bus.fifo_level !== '0) begin
            n_err++;
            $display("FAIL full_push_pop_tail: got last=%0h level=%0d need fee/0", bus.ram_addr, bus.fifo_level);
        end
        n_checks++;
    endtask

    task automatic test_saturate();
        fill_blocked(DEPTH);
        for (int i = 1; i <= 300; i++) begin
            bus.in_addr = ADDR_W'($urandom_range(0, 4095));
            bus.in_we   = 1'b1;
            cycle();
            if (i == 100 || i == 255 || i == 300) begin
                if (bus.drop_count !== 8'(m_cnt) || bus.drop_count !== 8'((i > 255) ? 255 : i)) begin
                    n_err++;
                    $display("FAIL saturate_count[%0d]: got %0d need %0d", i, bus.drop_count, (i > 255) ? 255 : i);
                end
                n_checks++;
            end
        end
        bus.in_we = 1'b0;
        if (bus.overflow !== 1'b1 || bus.fifo_level !== LVL_W'(DEPTH)) begin
            n_err++;
            $display("FAIL saturate_state: got ovf=%0h level=%0d need 1/16", bus.overflow, bus.fifo_level);
        end
        n_checks++;
        bus.clear_stats = 1'b1;
        bus.ram_busy    = 1'b0;
        cycle();
        bus.clear_stats = 1'b0;
        repeat (DEPTH) cycle();
    endtask

    task automatic test_reset_mid_drain();
        fill_blocked(10);
        bus.ram_busy = 1'b0;
        cycle();
        cycle();
        if (bus.fifo_level !== LVL_W'(8) || bus.ram_we !== 1'b1) begin
            n_err++;
            $display("FAIL mid_drain_setup: got level=%0d we=%0h need 8/1", bus.fifo_level, bus.ram_we);
        end
        n_checks++;
        #3 rst_n = 1'b0;
        #1;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== '0 || bus.ram_data !== '0 ||
            bus.fifo_level !== '0 || bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin
            n_err++;
            $display("FAIL async_reset: got we=%0h %0h/%0h level=%0d ovf=%0h cnt=%0d need all 0",
                     bus.ram_we, bus.ram_addr, bus.ram_data, bus.fifo_level, bus.overflow, bus.drop_count);
        end
        n_checks++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (bus.ram_we !== 1'b0 || bus.fifo_level !== '0) begin
                n_err++;
                $display("FAIL post_reset_stale[%0d]: got we=%0h level=%0d need 0/0", i, bus.ram_we, bus.fifo_level);
            end
            n_checks++;
        end
    endtask

    task automatic test_random();
        bit busy_mode;
        busy_mode = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) busy_mode = ~busy_mode;
            bus.ram_busy    = busy_mode ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
            bus.in_we       = ($urandom_range(0, 2) == 0);
            bus.in_addr     = ADDR_W'($urandom_range(0, 4095));
            bus.in_data     = DATA_W'($urandom_range(0, 4095));
            bus.clear_stats = ($urandom_range(0, 40) == 0);
            cycle();
            if (bus.ram_we !== m_we || bus.ram_addr !== m_out.addr || bus.ram_data !== m_out.data) begin
                n_err++;
                $display("FAIL random_port[%0d]: got we=%0h %0h/%0h need we=%0h %0h/%0h",
                         i, bus.ram_we, bus.ram_addr, bus.ram_data, m_we, m_out.addr, m_out.data);
            end
            n_checks++;
            if (bus.fifo_level !== LVL_W'(exp_q.size()) || bus.overflow !== m_ovf || bus.drop_count !== 8'(m_cnt)) begin
                n_err++;
                $display("FAIL random_status[%0d]: got level=%0d ovf=%0h cnt=%0d need %0d/%0h/%0d",
                         i, bus.fifo_level, bus.overflow, bus.drop_count, exp_q.size(), m_ovf, m_cnt);
            end
            n_checks++;
        end
        idle_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_write();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_saturate();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_write_queue.md
# fb_write_queue

Pixel-domain write buffer between the CPU→video CDC stage and the frame-buffer RAM write port. It accepts the single-cycle synchronized write pulses (address and data) and queues them in a small FIFO. It drains the queue into the RAM only in cycles when video scanout does not own the RAM port. Writes arriving while the queue is full are dropped, flagged and counted, and never stall the upstream.

## Interface
Parameters:
- `ADDR_W`, 12, frame-buffer address width
- `DATA_W`, 12, frame-buffer data width
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `LVL_W`, $clog2(DEPTH)+1, level counter width (derived)

Ports:
- `clk_pixel`  in  1  pixel clock, 51 MHz; all logic on rising edge
- `rst_pixel_n`  in  1  asynchronous, active-low reset
- `in_addr`  in  ADDR_W  write address, valid when `in_we`=1
- `in_data`  in  DATA_W  write data, valid when `in_we`=1
- `in_we`  in  1  single-cycle write request
- `ram_busy`  in  1  scanout owns the RAM port this cycle; no write may issue
- `clear_stats`  in  1  single-cycle; clears `overflow` and `drop_count`
- `ram_addr`  out  ADDR_W  RAM write address (registered)
- `ram_data`  out  DATA_W  RAM write data (registered)
- `ram_we`  out  1  RAM write strobe (registered, one cycle per entry)
- `fifo_level`  out  LVL_W  current occupancy, 0..DEPTH
- `overflow`  out  1  sticky: at least one write was dropped
- `drop_count`  out  8  dropped writes, saturating at 255

## Operation
- Storage: DEPTH×(ADDR_W+DATA_W) array, with `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits that wrap modulo DEPTH, plus the `fifo_level` register.
- `pop` = (`fifo_level` ≠ 0) & ~`ram_busy`. The decision uses registered level only.
- `push` = `in_we` & ((`fifo_level` < DEPTH) | `pop`). A write to a full queue is accepted when a pop happens in the same cycle.
- `drop` = `in_we` & ~`push`.
- Level update: +1 on push only, −1 on pop only, unchanged on both or neither. The level never exceeds DEPTH and never goes below 0.
- On pop: `ram_addr`/`ram_data` ← head entry, `ram_we` ← 1, `rd_ptr` advances. Otherwise `ram_we` ← 0 and `ram_addr`/`ram_data` hold their last values.
- Empty queue with simultaneous push: no bypass. The entry issues on a later cycle.
- On drop: `overflow` ← 1 and `drop_count` ← min(`drop_count`+1, 255).
- `clear_stats` with no drop: `overflow` ← 0, `drop_count` ← 0.
- `clear_stats` with a drop in the same cycle: `overflow` ← 1, `drop_count` ← 1.
- Ordering: entries retire strictly in arrival order. No coalescing of repeated addresses.
- Reset (asynchronous, any time, including mid-drain): all outputs, pointers and level go to 0, and queued entries are discarded. Array contents are don't-care.
  - Reset values: `ram_we`=0, `ram_addr`=0, `ram_data`=0, `fifo_level`=0, `overflow`=0, `drop_count`=0.

## Timing
- Accept latency: `in_we` sampled at edge k; the entry is stored and `fifo_level` increments after edge k.
- Minimum write latency: with `ram_busy`=0 at edge k+1, the pop happens at edge k+1 and `ram_we`=1 in the cycle following it. That is 2 clocks from `in_we` to `ram_we`.
- Throughput: one retire per cycle while `ram_busy`=0 and the queue is non-empty. One accept per cycle at all times.
- `ram_busy` is sampled combinationally at each edge. No write issues in any cycle that follows an edge where `ram_busy`=1.
- `fifo_level`, `overflow` and `drop_count` update at the same edge as the event that causes them.
- Upstream rate: the source delivers at most one pulse per ≥ 10 pixel clocks. DEPTH=16 therefore absorbs scanout blocking of up to ~160 cycles without drops.

## Structure
- Shared package `fb_pkg`:
  - `FB_ADDR_W`=12 and `FB_DATA_W`=12, reused by the CDC stage and the RAM.
  - Packed `fb_wr_t` {addr, data}.
  - `DROP_CNT_MAX`=255.
- Sub-module `fb_fifo_mem`: simple dual-port array, synchronous write, read at `rd_ptr`, so it infers distributed RAM or EBR.
- Pointers, level, pop/push/drop logic and statistics stay in the top module.

## Test plan
- Reset release, `ram_busy`=0, one write (addr 0x123, data 0xABC) → `ram_we`=1 exactly 2 clocks later with 0x123/0xABC; `fifo_level` returns to 0.
- `ram_busy`=1 held, 16 writes (addr 0..15) → `fifo_level`=16, `ram_we`=0 throughout; release `ram_busy` → 16 consecutive `ram_we` cycles, addresses 0..15 in order.
- Full queue, `ram_busy`=1, 3 more writes → `overflow`=1, `drop_count`=3, level stays 16; then `clear_stats` together with a 4th write → `overflow`=1, `drop_count`=1.
- Full queue, `ram_busy`=0, write at the same edge as the pop → push accepted, level stays 16, no drop.
- 300 writes into a full, blocked queue → `drop_count` saturates at 255.
- Assert `rst_pixel_n`=0 mid-drain with level 8 → all outputs 0 immediately; after release, no stale `ram_we`.
